mdc_commutator: RTL and testbench

- Sequential delay-commutator for radix-2 MDC FFT pipeline stages: two valid-gated D-deep delay lines around a 2x2 complex swap, driven by a mod-2D sample counter.
- Regroups two parallel complex streams so samples D apart land on the same output cycle for the next butterfly.
- Sits between butterfly stages of the 8–2048-point pipeline. One instance per stage; DELAY halves each stage.

---
 rtl/mdc_commutator.sv | 85 ++++++++
 tb/tb_mdc_commutator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mdc_commutator.sv
// mdc_commutator: radix-2 MDC delay commutator (bottom delay, 2x2 swap, top delay).
// Optional drain port flush is enabled by defining MDC_COMMUTATOR_FLUSH_EN.
module mdc_commutator #(
  parameter int DW    = 16,
  parameter int DELAY = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
`ifdef MDC_COMMUTATOR_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [DW-1:0] x0_re,
  input  logic [DW-1:0] x0_im,
  input  logic [DW-1:0] x1_re,
  input  logic [DW-1:0] x1_im,
  output logic          valid_out,
  output logic [DW-1:0] y0_re,
  output logic [DW-1:0] y0_im,
  output logic [DW-1:0] y1_re,
  output logic [DW-1:0] y1_im,
  output logic          primed
);
  localparam int LD = $clog2(DELAY);
  localparam int CW = LD + 1;
  logic            acc, sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            primed_q, primed_d, valid_q, valid_d;
  logic [2*DW-1:0] a_in, b_in, b_dly, t_dly, top_s, bot_s;
  logic [2*DW-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [2*DW-1:0] dlb_q [DELAY];
  logic [2*DW-1:0] dlt_q [DELAY];
`ifdef MDC_COMMUTATOR_FLUSH_EN
  // a flush cycle behaves as an accepted zero pair
  assign acc  = valid_in | flush;
  assign a_in = valid_in ? {x0_re, x0_im} : '0;
  assign b_in = valid_in ? {x1_re, x1_im} : '0;
`else
  assign acc  = valid_in;
  assign a_in = {x0_re, x0_im};
  assign b_in = {x1_re, x1_im};
`endif
  assign sel   = cnt_q[LD];
  assign b_dly = dlb_q[DELAY-1];
  assign t_dly = dlt_q[DELAY-1];
  assign top_s = sel ? b_dly : a_in;
  assign bot_s = sel ? a_in : b_dly;
  always_comb begin
    cnt_d    = acc ? cnt_q + CW'(1) : cnt_q;
    primed_d = primed_q | (acc && cnt_q == CW'(DELAY - 1));
    valid_d  = acc & primed_q;
    y0_d     = valid_d ? t_dly : y0_q;
    y1_d     = valid_d ? bot_s : y1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
      y0_q     <= '0;
      y1_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
    end
  end
  // delay contents are never emitted before refill, so they carry no reset
  always_ff @(posedge clk) begin
    if (acc) begin
      dlb_q[0] <= b_in;
      dlt_q[0] <= top_s;
      for (int i = 1; i < DELAY; i++) begin
        dlb_q[i] <= dlb_q[i-1];
        dlt_q[i] <= dlt_q[i-1];
      end
    end
  end
  assign valid_out = valid_q;
  assign primed    = primed_q;
  assign {y0_re, y0_im} = y0_q;
  assign {y1_re, y1_im} = y1_q;
endmodule

// File: tb/tb_mdc_commutator.sv
// tb_mdc_commutator: drives DELAY=4 and DELAY=1 commutators from one stream and checks
// both every cycle against a frame-indexing reference built from queues of accepted samples.
module tb_mdc_commutator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
`ifdef MDC_COMMUTATOR_FLUSH_EN
  logic flush = 1'b0;
`endif
  logic [15:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;
  logic        vo [2];
  logic        pr [2];
  logic [15:0] yr0 [2], yi0 [2], yr1 [2], yi1 [2];
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mdc_commutator #(.DW(16), .DELAY(4)) u4 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
`ifdef MDC_COMMUTATOR_FLUSH_EN
    .flush(flush),
`endif
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .valid_out(vo[0]), .y0_re(yr0[0]), .y0_im(yi0[0]), .y1_re(yr1[0]), .y1_im(yi1[0]),
    .primed(pr[0]));

  mdc_commutator #(.DW(16), .DELAY(1)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
`ifdef MDC_COMMUTATOR_FLUSH_EN
    .flush(flush),
`endif
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .valid_out(vo[1]), .y0_re(yr0[1]), .y0_im(yi0[1]), .y1_re(yr1[1]), .y1_im(yi1[1]),
    .primed(pr[1]));

  // reference: accepted samples since reset, {re,im}
  logic [31:0] qa[$], qb[$];
  logic [31:0] lg0[$], lg1[$];
  int          dly [2] = '{4, 1};
  logic        ev [2], ep [2];
  logic [31:0] e0 [2], e1 [2];

  initial for (int u = 0; u < 2; u++) begin
    ev[u] = 0; ep[u] = 0; e0[u] = 0; e1[u] = 0;
  end

  always @(posedge clk) begin
    logic acc;
    logic [31:0] a, b;
    int k, n, j, d;
    acc = valid_in;
    a = {x0_re, x0_im};
    b = {x1_re, x1_im};
`ifdef MDC_COMMUTATOR_FLUSH_EN
    acc = valid_in | flush;
    if (!valid_in) begin a = 0; b = 0; end
`endif
    if (rst) begin
      qa.delete(); qb.delete();
      for (int u = 0; u < 2; u++) begin
        ev[u] = 0; ep[u] = 0; e0[u] = 0; e1[u] = 0;
      end
    end else if (acc) begin
      qa.push_back(a); qb.push_back(b);
      k = qa.size() - 1;
      for (int u = 0; u < 2; u++) begin
        d = dly[u];
        n = k - d;
        ep[u] = (qa.size() >= d);
        ev[u] = (n >= 0);
        if (n >= 0) begin
          j = n % (2 * d);
          e0[u] = (j < d) ? qa[n] : qb[n-d];
          e1[u] = (j < d) ? qa[n+d] : qb[n];
        end
      end
    end else begin
      ev[0] = 0; ev[1] = 0;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      ntests++;
      if ({vo[u], pr[u], yr0[u], yi0[u], yr1[u], yi1[u]} !== {ev[u], ep[u], e0[u], e1[u]}) begin
        nfail++;
        $display("FAIL model D=%0d t=%0t got v=%b p=%b y0=%h%h y1=%h%h exp v=%b p=%b y0=%h y1=%h",
                 dly[u], $time, vo[u], pr[u], yr0[u], yi0[u], yr1[u], yi1[u], ev[u], ep[u], e0[u], e1[u]);
      end
    end
    if (vo[0]) lg0.push_back({yr0[0], yr1[0]});
    if (vo[1]) lg1.push_back({yr0[1], yr1[1]});
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic [15:0] ar, ai, br, bi);
    @(negedge clk);
    rst = 0; valid_in = v;
    x0_re = ar; x0_im = ai; x1_re = br; x1_im = bi;
  endtask

  task automatic drive(input logic v, input int k);
    put(v, 16'(k), 16'(16'h100 + k), 16'(16'h10 + k), 16'(16'h200 + k));
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1; valid_in = v;
    @(negedge clk);
    rst = 0; valid_in = 0;
    lg0.delete(); lg1.delete();
  endtask

  task automatic stream(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) drive(1, k);
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) drive(0, 0);
  endtask

  initial begin
    // basic frame
    do_reset(0);
    stream(0, 11); idle(2);
    chk("basic_cnt", 32'(lg0.size()), 32'd8);
    chk("basic_0", lg0[0], {16'd0, 16'd4});
    chk("basic_3", lg0[3], {16'd3, 16'd7});
    chk("basic_4", lg0[4], {16'h10, 16'h14});
    chk("basic_7", lg0[7], {16'h13, 16'h17});
    chk("d1_0", lg1[0], {16'd0, 16'd1});
    chk("d1_1", lg1[1], {16'h10, 16'h11});
    chk("d1_2", lg1[2], {16'd2, 16'd3});
    // stall between k=5 and k=6
    do_reset(0);
    stream(0, 5); idle(3); stream(6, 11); idle(2);
    chk("stall_cnt", 32'(lg0.size()), 32'd8);
    chk("stall_2", lg0[2], {16'd2, 16'd6});
    chk("stall_5", lg0[5], {16'h11, 16'h15});
    // back-to-back frames
    do_reset(0);
    stream(0, 23); idle(2);
    chk("b2b_cnt", 32'(lg0.size()), 32'd20);
    chk("b2b_8", lg0[8], {16'd8, 16'd12});
    chk("b2b_12", lg0[12], {16'h18, 16'h1C});
    chk("b2b_15", lg0[15], {16'h1B, 16'h1F});
    chk("b2b_16", lg0[16], {16'h10, 16'h14});
    // reset mid-frame, with valid_in high during reset (sample dropped)
    do_reset(0);
    stream(0, 6);
    do_reset(1);
    chk("rst_valid", {31'd0, vo[0]}, 32'd0);
    chk("rst_primed", {31'd0, pr[0]}, 32'd0);
    stream(0, 4); idle(2);
    chk("rst_cnt", 32'(lg0.size()), 32'd1);
    chk("rst_first", lg0[0], {16'd0, 16'd4});
`ifdef MDC_COMMUTATOR_FLUSH_EN
    do_reset(0);
    stream(0, 7);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0); flush = 1;
    end
    @(negedge clk); flush = 0;
    idle(2);
    chk("flush_cnt", 32'(lg0.size()), 32'd8);
    chk("flush_4", lg0[4], {16'h10, 16'h14});
    chk("flush_7", lg0[7], {16'h13, 16'h17});
`endif
    // randomized stream with stalls and occasional resets
    do_reset(0);
    for (int i = 0; i < 600; i++) begin
      put($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
`ifdef MDC_COMMUTATOR_FLUSH_EN
      flush = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 199) == 0) rst = 1;
    end
`ifdef MDC_COMMUTATOR_FLUSH_EN
    flush = 0;
`endif
    idle(3);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
